operand_builder: RTL and testbench
==================================

OPERAND_BUILDER -- requirements
Module: operand_builder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_key_data, input, 5 bits: key code; 0xxxx = digit xxxx, 10000 = AC, 10001 = +, 10010 = -, 10011 = *, 10100 = /, 10101 = =.
REQ-005 SHALL have ports i_key_valid (input, 1 bit) and o_key_ready (output, 1 bit): the key handshake; a key is consumed only on a cycle where both are 1.
REQ-006 SHALL have ports o_alu_a and o_alu_b (output, WIDTH bits each) and o_alu_op (output, 2 bits: 00 add, 01 sub, 10 mul, 11 div).
REQ-007 SHALL have ports o_alu_valid (output, 1 bit) and i_alu_ready (input, 1 bit): the operation-issue handshake.
REQ-008 SHALL have ports i_res_data (input, WIDTH bits), i_res_err (input, 1 bit), i_res_valid (input, 1 bit) and o_res_ready (output, 1 bit): the result return handshake.
REQ-009 SHALL have ports o_disp_value (output, WIDTH bits: the value to display) and o_error (output, 1 bit: sticky error flag).

Function
REQ-010 SHALL implement the FSM states S_A (entering A), S_OP (operator latched, B empty), S_B (entering B), S_ISSUE, S_WAIT and S_RES (A holds the last result).
REQ-011 SHALL drive o_key_ready = 1 in S_A, S_OP, S_B and S_RES, and 0 in S_ISSUE and S_WAIT.
REQ-012 SHALL accumulate a digit d as X <= X*BASE + d; if the result would exceed 2^WIDTH-1, the digit SHALL be consumed and X left unchanged (no wrap-around).
REQ-013 On AC in any accepting state, SHALL set A = 0, B = 0, op = 00, clear the pending flag, clear o_error, and go to S_A.
REQ-014 In S_A: a digit SHALL accumulate into A; an operator SHALL latch op and go to S_OP; = SHALL be ignored.
REQ-015 In S_OP: a digit SHALL set B = d and go to S_B; an operator SHALL replace op; = SHALL be ignored.
REQ-016 In S_B: a digit SHALL accumulate into B; = SHALL go to S_ISSUE with pending cleared; an operator SHALL go to S_ISSUE with pending set and pending_op = the new operator.
REQ-017 In S_RES: a digit SHALL set A = d, B = 0 and go to S_A; an operator SHALL latch op and go to S_OP; = SHALL be ignored.
REQ-018 In S_ISSUE, o_alu_valid SHALL be 1 with o_alu_a = A, o_alu_b = B and o_alu_op = op, all held stable until i_alu_ready; the state SHALL then move to S_WAIT the following cycle.
REQ-019 o_res_ready SHALL be 1 only in S_WAIT.
REQ-020 On i_res_valid in S_WAIT, SHALL set A = i_res_data and B = 0.
REQ-021 After the result in REQ-020: if pending is set, SHALL set op = pending_op and go to S_OP; otherwise SHALL go to S_RES.
REQ-022 If i_res_err = 1 with the result, SHALL set o_error = 1 and A = 0; o_error SHALL clear only on AC or reset.
REQ-023 o_disp_value SHALL be B in S_B, S_ISSUE and S_WAIT, and A otherwise.
REQ-024 Key consumption SHALL take effect one cycle after the handshake; there SHALL be no bubble, so back-to-back keys are accepted on consecutive cycles.
REQ-025 Non-digit codes outside the defined set (10110 to 11111) SHALL be consumed and ignored.

Reset
REQ-026 On reset, SHALL enter S_A with A = 0, B = 0, op = 00, pending = 0 and o_error = 0.
REQ-027 On reset, SHALL drive o_alu_valid = 0, o_res_ready = 0 and o_key_ready = 1 (after release).
REQ-028 Reset asserted mid-issue or mid-wait SHALL abandon the operation; no late result is captured.

Configuration
REQ-029 SHALL support macro HEX_ENTRY_EN. When defined: BASE = 16, and digit codes 0 to 15 are all valid. When undefined: BASE = 10, and digit codes 10 to 15 are consumed and ignored.

Verification
REQ-030 Keys 1,2,+,3,= -> one issue with a = 12, b = 3, op = 00; result 15 -> S_RES, o_disp_value = 15.
REQ-031 Keys 9,*,4,-,2,= with the ALU returning 36 -> second issue a = 36, b = 2, op = 01 (chained via the pending flag).
REQ-032 WIDTH = 16, decimal build: keys 6,5,5,3,5 -> A = 65535; a further key 1 -> A stays 65535.
REQ-033 Keys 8,/,0,= with i_res_err = 1 -> o_error = 1 and A = 0; then AC -> o_error = 0, state S_A.
REQ-034 i_alu_ready held 0 for 5 cycles -> o_alu_valid and its operands stay stable, o_key_ready = 0, and an offered key is not consumed.
REQ-035 Key code 01100: without HEX_ENTRY_EN -> A unchanged; with it -> A = 12.

Source files
------------

// File: rtl/operand_builder.sv
// Calculator front end: turns key codes into ALU operands/operator, issues the
// operation, and collects the result. Define HEX_ENTRY_EN for base-16 entry.
module operand_builder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       i_key_data,
   input  logic             i_key_valid,
   output logic             o_key_ready,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic [1:0]       o_alu_op,
   output logic             o_alu_valid,
   input  logic             i_alu_ready,
   input  logic [WIDTH-1:0] i_res_data,
   input  logic             i_res_err,
   input  logic             i_res_valid,
   output logic             o_res_ready,
   output logic [WIDTH-1:0] o_disp_value,
   output logic             o_error
);

   localparam logic [2:0] S_A     = 3'd0;
   localparam logic [2:0] S_OP    = 3'd1;
   localparam logic [2:0] S_B     = 3'd2;
   localparam logic [2:0] S_ISSUE = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_RES   = 3'd5;

`ifdef HEX_ENTRY_EN
   localparam logic [WIDTH+4:0] L_BASE = (WIDTH+5)'(16);
`else
   localparam logic [WIDTH+4:0] L_BASE = (WIDTH+5)'(10);
`endif

   logic [2:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic             r_pend;
   logic [1:0]       r_pend_op;
   logic             r_error;

   logic             w_fire;
   logic             w_digit_ok;
   logic             w_is_ac;
   logic             w_is_opk;
   logic             w_is_eq;
   logic [1:0]       w_key_op;
   logic [3:0]       w_digit;
   logic [WIDTH-1:0] w_digit_ext;
   logic [WIDTH-1:0] w_a_acc;
   logic [WIDTH-1:0] w_b_acc;

   // Saturating digit append: an overflowing digit leaves the operand untouched.
   function automatic logic [WIDTH-1:0] f_accum(input logic [WIDTH-1:0] x, input logic [3:0] d);
      logic [WIDTH+4:0] v;
      v = ({5'd0, x} * L_BASE) + {{(WIDTH+1){1'b0}}, d};
      if (v > {5'd0, {WIDTH{1'b1}}}) begin
         return x;
      end else begin
         return v[WIDTH-1:0];
      end
   endfunction

   // Key decode and handshake qualification.
   always_comb begin
      w_fire      = i_key_valid & o_key_ready;
      w_digit     = i_key_data[3:0];
      w_digit_ext = {{(WIDTH-4){1'b0}}, i_key_data[3:0]};
`ifdef HEX_ENTRY_EN
      w_digit_ok  = ~i_key_data[4];
`else
      w_digit_ok  = ~i_key_data[4] && (i_key_data[3:0] < 4'd10);
`endif
      w_is_ac     = (i_key_data == 5'b10000);
      w_is_eq     = (i_key_data == 5'b10101);
      w_is_opk    = 1'b1;
      w_key_op    = 2'b00;
      case (i_key_data)
         5'b10001: w_key_op = 2'b00;
         5'b10010: w_key_op = 2'b01;
         5'b10011: w_key_op = 2'b10;
         5'b10100: w_key_op = 2'b11;
         default:  w_is_opk = 1'b0;
      endcase
      w_a_acc     = f_accum(r_a, w_digit);
      w_b_acc     = f_accum(r_b, w_digit);
   end

   // Output decode from registered state.
   always_comb begin
      o_key_ready  = (r_state == S_A) || (r_state == S_OP) || (r_state == S_B) || (r_state == S_RES);
      o_alu_valid  = (r_state == S_ISSUE);
      o_res_ready  = (r_state == S_WAIT);
      o_alu_a      = r_a;
      o_alu_b      = r_b;
      o_alu_op     = r_op;
      o_error      = r_error;
      if ((r_state == S_B) || (r_state == S_ISSUE) || (r_state == S_WAIT)) begin
         o_disp_value = r_b;
      end else begin
         o_disp_value = r_a;
      end
   end

   // Main sequencer: key entry, operation issue, result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_A;
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= 2'b00;
         r_pend    <= 1'b0;
         r_pend_op <= 2'b00;
         r_error   <= 1'b0;
      end else if (w_fire && w_is_ac) begin
         r_state   <= S_A;
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= 2'b00;
         r_pend    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         case (r_state)
            S_A: begin
               if (w_fire && w_digit_ok) begin
                  r_a <= w_a_acc;
               end else if (w_fire && w_is_opk) begin
                  r_op    <= w_key_op;
                  r_state <= S_OP;
               end
            end
            S_OP: begin
               if (w_fire && w_digit_ok) begin
                  r_b     <= w_digit_ext;
                  r_state <= S_B;
               end else if (w_fire && w_is_opk) begin
                  r_op <= w_key_op;
               end
            end
            S_B: begin
               if (w_fire && w_digit_ok) begin
                  r_b <= w_b_acc;
               end else if (w_fire && w_is_eq) begin
                  r_pend  <= 1'b0;
                  r_state <= S_ISSUE;
               end else if (w_fire && w_is_opk) begin
                  // Operator after B chains: issue now, apply this operator to the result.
                  r_pend    <= 1'b1;
                  r_pend_op <= w_key_op;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (i_alu_ready) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_res_valid) begin
                  r_b <= '0;
                  if (i_res_err) begin
                     r_a     <= '0;
                     r_error <= 1'b1;
                  end else begin
                     r_a <= i_res_data;
                  end
                  if (r_pend) begin
                     r_op    <= r_pend_op;
                     r_pend  <= 1'b0;
                     r_state <= S_OP;
                  end else begin
                     r_state <= S_RES;
                  end
               end
            end
            S_RES: begin
               if (w_fire && w_digit_ok) begin
                  r_a     <= w_digit_ext;
                  r_b     <= '0;
                  r_state <= S_A;
               end else if (w_fire && w_is_opk) begin
                  r_op    <= w_key_op;
                  r_state <= S_OP;
               end
            end
            default: r_state <= S_A;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_builder.sv
// Directed-vector bench for operand_builder (decimal build, WIDTH = 16).
module tb_operand_builder;

   localparam int W = 16;
   localparam logic [4:0] K_AC = 5'b10000, K_ADD = 5'b10001, K_SUB = 5'b10010,
                          K_MUL = 5'b10011, K_DIV = 5'b10100, K_EQ = 5'b10101;

   logic         clk;
   logic         rst_n;
   logic [4:0]   i_key_data;
   logic         i_key_valid;
   logic         o_key_ready;
   logic [W-1:0] o_alu_a;
   logic [W-1:0] o_alu_b;
   logic [1:0]   o_alu_op;
   logic         o_alu_valid;
   logic         i_alu_ready;
   logic [W-1:0] i_res_data;
   logic         i_res_err;
   logic         i_res_valid;
   logic         o_res_ready;
   logic [W-1:0] o_disp_value;
   logic         o_error;

   int n_tests = 0;
   int n_fail  = 0;

   operand_builder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_key_data(i_key_data), .i_key_valid(i_key_valid), .o_key_ready(o_key_ready),
      .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
      .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready),
      .i_res_data(i_res_data), .i_res_err(i_res_err), .i_res_valid(i_res_valid),
      .o_res_ready(o_res_ready), .o_disp_value(o_disp_value), .o_error(o_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic key(input logic [4:0] k);
      int n;
      n = 0;
      i_key_data  = k;
      i_key_valid = 1'b1;
      while (!o_key_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check("key_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      i_key_valid = 1'b0;
   endtask

   task automatic issue(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                        input logic [1:0] eop);
      int n;
      n = 0;
      while (!o_alu_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_valid"}, 32'(o_alu_valid), 32'd1);
      check({tag, "_a"}, 32'(o_alu_a), 32'(ea));
      check({tag, "_b"}, 32'(o_alu_b), 32'(eb));
      check({tag, "_op"}, 32'(o_alu_op), 32'(eop));
      i_alu_ready = 1'b1;
      @(posedge clk); #1;
      i_alu_ready = 1'b0;
   endtask

   task automatic result(input logic [W-1:0] d, input logic err);
      int n;
      n = 0;
      while (!o_res_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check("res_timeout", 32'd0, 32'd1);
      i_res_data  = d;
      i_res_err   = err;
      i_res_valid = 1'b1;
      @(posedge clk); #1;
      i_res_valid = 1'b0;
      i_res_err   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; i_key_data = 5'd0; i_key_valid = 1'b0; i_alu_ready = 1'b0;
      i_res_data = '0; i_res_err = 1'b0; i_res_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_disp", 32'(o_disp_value), 32'd0);
      check("rst_key_ready", 32'(o_key_ready), 32'd1);
      check("rst_alu_valid", 32'(o_alu_valid), 32'd0);
      check("rst_res_ready", 32'(o_res_ready), 32'd0);
      check("rst_error", 32'(o_error), 32'd0);

      // 12 + 3 = 15
      key(5'd1); key(5'd2);
      check("a12_disp", 32'(o_disp_value), 32'd12);
      key(K_ADD);
      check("op_disp", 32'(o_disp_value), 32'd12);
      key(5'd3);
      check("b3_disp", 32'(o_disp_value), 32'd3);
      key(K_EQ);
      check("issue_key_ready", 32'(o_key_ready), 32'd0);
      issue("add", 16'd12, 16'd3, 2'b00);
      check("wait_res_ready", 32'(o_res_ready), 32'd1);
      result(16'd15, 1'b0);
      check("res_disp", 32'(o_disp_value), 32'd15);
      check("res_key_ready", 32'(o_key_ready), 32'd1);
      check("res_alu_valid", 32'(o_alu_valid), 32'd0);
      key(K_EQ);
      check("res_eq_ignored", 32'(o_disp_value), 32'd15);
      key(5'd7);
      check("res_digit_new_a", 32'(o_disp_value), 32'd7);

      // Chained: 9 * 4 - 2 =
      key(K_AC);
      key(5'd9); key(K_MUL); key(5'd4); key(K_SUB);
      issue("mul", 16'd9, 16'd4, 2'b10);
      result(16'd36, 1'b0);
      check("chain_disp", 32'(o_disp_value), 32'd36);
      check("chain_key_ready", 32'(o_key_ready), 32'd1);
      key(5'd2); key(K_EQ);
      issue("sub", 16'd36, 16'd2, 2'b01);
      result(16'd34, 1'b0);
      check("chain_res", 32'(o_disp_value), 32'd34);

      // Operator replacement in S_OP: 4 + - 1 =
      key(K_AC);
      key(5'd4); key(K_ADD); key(K_SUB); key(5'd1); key(K_EQ);
      issue("repl", 16'd4, 16'd1, 2'b01);
      result(16'd3, 1'b0);

      // Saturation at 65535
      key(K_AC);
      key(5'd6); key(5'd5); key(5'd5); key(5'd3); key(5'd5);
      check("sat_max", 32'(o_disp_value), 32'd65535);
      key(5'd1);
      check("sat_hold", 32'(o_disp_value), 32'd65535);

      // Divide by zero error, then AC
      key(K_AC);
      key(5'd8); key(K_DIV); key(5'd0); key(K_EQ);
      issue("div", 16'd8, 16'd0, 2'b11);
      result(16'hFFFF, 1'b1);
      check("err_flag", 32'(o_error), 32'd1);
      check("err_a_zero", 32'(o_disp_value), 32'd0);
      key(5'd2);
      check("err_sticky", 32'(o_error), 32'd1);
      key(K_AC);
      check("ac_err_clear", 32'(o_error), 32'd0);
      check("ac_disp", 32'(o_disp_value), 32'd0);
      check("ac_key_ready", 32'(o_key_ready), 32'd1);

      // ALU stall: 5 + 6 with ready low for 5 cycles and a key offered
      key(5'd5); key(K_ADD); key(5'd6); key(K_EQ);
      i_key_data = 5'd7; i_key_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check("stall_valid", 32'(o_alu_valid), 32'd1);
         check("stall_a", 32'(o_alu_a), 32'd5);
         check("stall_b", 32'(o_alu_b), 32'd6);
         check("stall_op", 32'(o_alu_op), 32'd0);
         check("stall_key_ready", 32'(o_key_ready), 32'd0);
         @(posedge clk); #1;
      end
      i_key_valid = 1'b0;
      issue("stall", 16'd5, 16'd6, 2'b00);
      result(16'd11, 1'b0);
      check("stall_res", 32'(o_disp_value), 32'd11);

      // Hex digit and undefined code ignored in decimal build
      key(K_AC);
      key(5'd3); key(5'b01100);
      check("hex_ignored", 32'(o_disp_value), 32'd3);
      key(5'b10110);
      check("undef_ignored", 32'(o_disp_value), 32'd3);
      key(K_ADD);
      key(5'b11111);
      key(5'd4);
      check("undef_in_op", 32'(o_disp_value), 32'd4);

      // Reset mid-wait abandons the operation
      key(K_AC);
      key(5'd1); key(K_ADD); key(5'd1); key(K_EQ);
      i_alu_ready = 1'b1;
      @(posedge clk); #1;
      i_alu_ready = 1'b0;
      check("mid_wait", 32'(o_res_ready), 32'd1);
      i_res_data = 16'd99; i_res_valid = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_wait_res_ready", 32'(o_res_ready), 32'd0);
      check("rst_wait_disp", 32'(o_disp_value), 32'd0);
      check("rst_wait_key_ready", 32'(o_key_ready), 32'd1);
      i_res_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
